// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: default PC geometry and the
// fetch FSM state encodings.
package riscv_pkg;

  localparam int PC_W_DEF     = 6;
  localparam int RESET_PC_DEF = 0;
  localparam int REDIR_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch controller.
// Priority: redirect target, then sequential increment (wraps modulo 2^PC_W),
// otherwise hold. Halt gating is applied by the caller through the qualifiers.
module pc_next_sel #(
  parameter int PC_W = 6
) (
  input  logic [PC_W-1:0] pc_q,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            incr,
  output logic [PC_W-1:0] pc_next
);

  // Select the PC to load on the next rising edge
  always_comb begin
    pc_next = pc_q;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (incr) begin
      pc_next = pc_q + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller with a one-entry fetch slot.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | out of reset, no request; moves to FETCH next cycle
// ST_FETCH | requesting while the slot is empty or being consumed
// ST_FLUSH | one dead cycle after a redirect, no request issued
// ST_HALT  | halted, no request, inputs ignored; left only via rst
//
// Optional build macro FETCH_PERF_CNT_EN adds redirect_cnt_o, a saturating
// 8-bit count of accepted redirects.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt_i,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            imem_ack_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  output logic            fetch_valid_o,
  output logic [PC_W-1:0] fetch_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [REDIR_CNT_W-1:0] redirect_cnt_o
`endif
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic            live;
  logic            halt_take;
  logic            redir_take;
  logic            ack_take;

  // Halt outranks redirect, which outranks a returning ack; HALT ignores all.
  assign live       = (state_q != ST_HALT);
  assign halt_take  = live && halt_i;
  assign redir_take = live && !halt_i && redirect_valid_i;
  assign ack_take   = imem_req_o && imem_ack_i && !halt_i && !redirect_valid_i;

  assign imem_addr_o = pc_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FETCH, ST_FLUSH: begin
        if (halt_i) begin
          state_d = ST_HALT;
        end else if (redirect_valid_i) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request output: only in FETCH, and only when the slot can take a new entry
  always_comb begin
    imem_req_o = 1'b0;
    if (state_q == ST_FETCH) begin
      imem_req_o = !fetch_valid_o || !stall_i;
    end
  end

  pc_next_sel #(
    .PC_W (PC_W)
  ) u_pc_next_sel (
    .pc_q        (pc_q),
    .redirect    (redir_take),
    .redirect_pc (redirect_pc_i),
    .incr        (ack_take),
    .pc_next     (pc_next)
  );

  // Program counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_W'(RESET_PC);
    end else begin
      pc_q <= pc_next;
    end
  end

  // Fetch slot: filled by an accepted ack, drained on consume, killed by halt/redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_o <= 1'b0;
      fetch_pc_o    <= '0;
    end else if (halt_take || redir_take) begin
      fetch_valid_o <= 1'b0;
    end else if (ack_take) begin
      fetch_valid_o <= 1'b1;
      fetch_pc_o    <= pc_q;
    end else if (fetch_valid_o && !stall_i) begin
      fetch_valid_o <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [REDIR_CNT_W-1:0] redir_cnt_q;

  // Saturating count of accepted redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_cnt_q <= '0;
    end else if (redir_take && (redir_cnt_q != '1)) begin
      redir_cnt_q <= redir_cnt_q + REDIR_CNT_W'(1);
    end
  end

  assign redirect_cnt_o = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl at default parameters (PC_W=6, RESET_PC=0).
// The redirect counter section is active only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_ctrl;

  logic       clk;
  logic       rst;
  logic       halt_i;
  logic       redirect_valid_i;
  logic [5:0] redirect_pc_i;
  logic       imem_ack_i;
  logic       stall_i;
  logic       imem_req_o;
  logic [5:0] imem_addr_o;
  logic       fetch_valid_o;
  logic [5:0] fetch_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [7:0] redirect_cnt_o;
`endif

  int n_vec;
  int n_err;

  fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .halt_i           (halt_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_ack_i       (imem_ack_i),
    .stall_i          (stall_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_pc_o       (fetch_pc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .redirect_cnt_o   (redirect_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [5:0] pc);
    chk({tag, ".valid"}, 32'(fetch_valid_o), 32'(v));
    if (v) chk({tag, ".pc"}, 32'(fetch_pc_o), 32'(pc));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    halt_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 6'd0;
    imem_ack_i = 1'b0;
    stall_i = 1'b0;

    // Reset state
    #3;
    chk("rst.req",   32'(imem_req_o),    32'd0);
    chk("rst.addr",  32'(imem_addr_o),   32'd0);
    chk("rst.valid", 32'(fetch_valid_o), 32'd0);
    chk("rst.fpc",   32'(fetch_pc_o),    32'd0);
    tick(2);
    rst = 1'b0;
    imem_ack_i = 1'b1;
    #1;
    chk("idle.req", 32'(imem_req_o), 32'd0);

    // Streaming fetch: first valid two edges after leaving reset
    tick(1);
    chk("fetch.req",   32'(imem_req_o),    32'd1);
    chk("fetch.addr0", 32'(imem_addr_o),   32'd0);
    chk("fetch.nv",    32'(fetch_valid_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_slot($sformatf("stream%0d", i), 1'b1, 6'(i));
    end
    chk("stream.addr", 32'(imem_addr_o), 32'd4);

    // Stall holds the slot and blocks requests
    imem_ack_i = 1'b0;
    stall_i = 1'b1;
    #1;
    chk("stall.req0", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_slot($sformatf("stall%0d", i), 1'b1, 6'd3);
      chk($sformatf("stall%0d.req", i),  32'(imem_req_o),  32'd0);
      chk($sformatf("stall%0d.addr", i), 32'(imem_addr_o), 32'd4);
    end
    stall_i = 1'b0;
    #1;
    chk("unstall.req", 32'(imem_req_o), 32'd1);
    imem_ack_i = 1'b1;
    tick(1);
    chk_slot("resume", 1'b1, 6'd4);
    imem_ack_i = 1'b0;
    tick(1);
    chk("drain.valid", 32'(fetch_valid_o), 32'd0);
    chk("drain.addr",  32'(imem_addr_o),   32'd5);

    // Ack while no request is outstanding is ignored
    imem_ack_i = 1'b1;
    tick(1);
    chk_slot("fill5", 1'b1, 6'd5);
    stall_i = 1'b1;
    tick(1);
    chk_slot("ignack", 1'b1, 6'd5);
    chk("ignack.addr", 32'(imem_addr_o), 32'd6);
    stall_i = 1'b0;
    imem_ack_i = 1'b0;
    tick(1);
    chk("ignack.drain", 32'(fetch_valid_o), 32'd0);

    // Redirect beats a simultaneous ack, then one FLUSH cycle
    imem_ack_i = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 6'h20;
    tick(1);
    redirect_valid_i = 1'b0;
    #1;
    chk("redir.valid", 32'(fetch_valid_o), 32'd0);
    chk("redir.req",   32'(imem_req_o),    32'd0);
    chk("redir.addr",  32'(imem_addr_o),   32'h20);
    tick(1);
    chk("flush.req",   32'(imem_req_o),    32'd1);
    chk("flush.addr",  32'(imem_addr_o),   32'h20);
    chk("flush.valid", 32'(fetch_valid_o), 32'd0);
    tick(1);
    chk_slot("post_redir", 1'b1, 6'h20);

    // Second redirect during FLUSH reloads and extends the flush; then wrap
    imem_ack_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 6'h3E;
    tick(1);
    chk("dbl1.addr", 32'(imem_addr_o), 32'h3E);
    redirect_pc_i = 6'h3F;
    tick(1);
    redirect_valid_i = 1'b0;
    imem_ack_i = 1'b1;
    #1;
    chk("dbl2.addr", 32'(imem_addr_o), 32'h3F);
    chk("dbl2.req",  32'(imem_req_o),  32'd0);
    tick(1);
    chk("dbl3.req", 32'(imem_req_o), 32'd1);
    tick(1);
    chk_slot("wrap63", 1'b1, 6'h3F);
    chk("wrap.addr", 32'(imem_addr_o), 32'd0);
    tick(1);
    chk_slot("wrap0", 1'b1, 6'd0);
    chk("wrap.addr1", 32'(imem_addr_o), 32'd1);

    // Halt during a pending request: request drops, PC frozen, inputs ignored
    halt_i = 1'b1;
    tick(1);
    halt_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 6'h11;
    #1;
    chk("halt.req",   32'(imem_req_o),    32'd0);
    chk("halt.valid", 32'(fetch_valid_o), 32'd0);
    chk("halt.addr",  32'(imem_addr_o),   32'd1);
    tick(4);
    chk("halt4.req",  32'(imem_req_o),    32'd0);
    chk("halt4.addr", 32'(imem_addr_o),   32'd1);
    redirect_valid_i = 1'b0;

    // Asynchronous reset out of HALT, then a mid-stream reset
    #2;
    rst = 1'b1;
    #1;
    chk("hrst.addr", 32'(imem_addr_o), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(3);
    chk_slot("rerun", 1'b1, 6'd1);
    chk("rerun.addr", 32'(imem_addr_o), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst.addr",  32'(imem_addr_o),   32'd0);
    chk("mrst.valid", 32'(fetch_valid_o), 32'd0);
    chk("mrst.req",   32'(imem_req_o),    32'd0);
    chk("mrst.fpc",   32'(fetch_pc_o),    32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("mrel.addr", 32'(imem_addr_o), 32'd0);
    chk("mrel.req",  32'(imem_req_o),  32'd1);
    tick(1);
    chk_slot("mrel", 1'b1, 6'd0);

`ifdef FETCH_PERF_CNT_EN
    // Redirect counter saturates
    #2;
    rst = 1'b1;
    #1;
    chk("cnt.rst", 32'(redirect_cnt_o), 32'd0);
    tick(1);
    rst = 1'b0;
    imem_ack_i = 1'b0;
    redirect_valid_i = 1'b1;
    tick(3);
    chk("cnt.3", 32'(redirect_cnt_o), 32'd3);
    tick(297);
    chk("cnt.sat", 32'(redirect_cnt_o), 32'd255);
    redirect_valid_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
